// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner.
// - state_t     : sequencing FSM states
// - DEF_*       : default timing constants (125 MHz system clock)
// - cnt_width() : counter width helper that never returns zero
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_250_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 62_500_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 12_500_000;  // 100 ms
  localparam int DEF_REPEAT_EN       = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    REPEAT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1. At least 1, so that n = 1 still gives a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw button.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   raw   : raw asynchronous bouncing input, 1 = pressed
//   level : debounced level
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      count <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any agreeing sample restarts the stability window.
      if (sync2 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync2;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Turns two raw up/down push buttons into single-cycle step pulses for an
// up/down counter. Supports hold-to-auto-repeat and locks out when both
// buttons are pressed.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   btn_up   : raw up button, 1 = pressed
//   btn_down : raw down button, 1 = pressed
//   enable   : registered one-cycle step pulse
//   up_down  : registered direction, 1 = up, 0 = down; valid with enable
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic up_down
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("btn_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("btn_conditioner: REPEAT_PERIOD must be >= 1");
  end

  localparam int             MAX_DELAY   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
  localparam int             TW          = cnt_width(MAX_DELAY);
  localparam logic [TW-1:0]  DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
  localparam bit             REP_ON      = (REPEAT_EN != 0);

  logic          lvl_up;
  logic          lvl_down;
  logic          prev_up;
  logic          prev_down;
  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          enable_n;
  logic          up_down_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (lvl_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .level (lvl_down)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      enable    <= 1'b0;
      up_down   <= 1'b1;
      prev_up   <= 1'b0;
      prev_down <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      enable    <= enable_n;
      up_down   <= up_down_n;
      prev_up   <= lvl_up;
      prev_down <= lvl_down;
    end
  end

  logic rise_up;
  logic rise_down;
  logic active;
  logic other;

  assign rise_up   = lvl_up & ~prev_up;
  assign rise_down = lvl_down & ~prev_down;
  // up_down remembers which button owns the current press.
  assign active    = up_down ? lvl_up : lvl_down;
  assign other     = up_down ? lvl_down : lvl_up;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    enable_n  = 1'b0;
    up_down_n = up_down;
    unique case (state)
      IDLE: begin
        if (rise_up && rise_down) begin
          state_n = LOCKOUT;
        end else if (rise_up || rise_down) begin
          state_n   = HELD;
          enable_n  = 1'b1;
          up_down_n = rise_up;
          timer_n   = DELAY_LOAD;
        end
      end
      HELD, REPEAT: begin
        // Release and lockout outrank a timer expiring in the same cycle.
        if (!active) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (other) begin
          state_n = LOCKOUT;
          timer_n = '0;
        end else if (timer == '0) begin
          if (REP_ON) begin
            state_n  = REPEAT;
            enable_n = 1'b1;
            timer_n  = PERIOD_LOAD;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      LOCKOUT: begin
        if (!lvl_up && !lvl_down) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing constants.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic en;
  logic ud;
  logic b_down = 1'b0;
  logic b_up = 1'b0;
  logic en_once;
  logic ud_once;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (en),
    .up_down  (ud)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (0)
  ) dut_once (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (b_up),
    .btn_down (b_down),
    .enable   (en_once),
    .up_down  (ud_once)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int pulse_cyc[$];
  int pulse_dir[$];
  int model_cnt = 0;
  int back2back = 0;
  int ud_glitch = 0;
  int once_pulses = 0;
  logic en_prev = 1'b0;
  logic ud_prev = 1'b1;
  logic rst_prev = 1'b0;

  always @(negedge clk) begin
    if (en) begin
      pulse_cyc.push_back(cyc);
      pulse_dir.push_back(int'(ud));
      model_cnt = model_cnt + (ud ? 1 : -1);
    end
    if (en && en_prev) back2back++;
    if (rst && rst_prev && (ud != ud_prev) && !en) ud_glitch++;
    if (en_once) once_pulses++;
    en_prev  = en;
    ud_prev  = ud;
    rst_prev = rst;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_dir.delete();
  endtask

  int p;
  int r;
  int exp_off[6] = '{0, 20, 28, 36, 44, 52};

  initial begin
    // Reset state
    step(3);
    check("rst_enable", int'(en), 0);
    check("rst_up_down", int'(ud), 1);
    rst = 1'b1;
    step(3);

    // Clean press: raw change after edge p is sampled at p+1, pulse follows edge p+7
    clear_log();
    p = cyc;
    btn_up = 1'b1;
    step(10);
    btn_up = 0;
    step(15);
    check("clean_count", pulse_cyc.size(), 1);
    check("clean_time", (pulse_cyc.size() > 0) ? pulse_cyc[0] - p : -1, 7);
    check("clean_dir", (pulse_dir.size() > 0) ? pulse_dir[0] : -1, 1);
    check("clean_model", model_cnt, 1);

    // Bounce: 2-cycle high bursts never reach 4 stable cycles
    clear_log();
    for (int i = 0; i < 6; i++) begin
      btn_down = (i % 2 == 0);
      step(2);
    end
    p = cyc;
    btn_down = 1'b1;
    step(6);
    btn_down = 1'b0;
    step(15);
    check("bounce_count", pulse_cyc.size(), 1);
    check("bounce_time", (pulse_cyc.size() > 0) ? pulse_cyc[0] - p : -1, 7);
    check("bounce_dir", (pulse_dir.size() > 0) ? pulse_dir[0] : -1, 0);
    check("bounce_model", model_cnt, 0);

    // Auto-repeat: the would-be pulse at +60 coincides with the release and is dropped
    clear_log();
    p = cyc;
    btn_up = 1'b1;
    step(60);
    btn_up = 1'b0;
    step(20);
    check("repeat_count", pulse_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("repeat_t%0d", i),
            (pulse_cyc.size() > i) ? pulse_cyc[i] - p : -1, 7 + exp_off[i]);
    end
    check("repeat_model", model_cnt, 6);

    // Lockout: second button kills the repeat that would have fired at p+27 and p+35
    clear_log();
    p = cyc;
    btn_up = 1'b1;
    step(5);
    btn_down = 1'b1;
    step(30);
    check("lock_held_count", pulse_cyc.size(), 1);
    btn_up = 1'b0;
    btn_down = 1'b0;
    step(15);
    check("lock_rel_count", pulse_cyc.size(), 1);
    p = cyc;
    btn_down = 1'b1;
    step(10);
    btn_down = 1'b0;
    step(15);
    check("lock_next_count", pulse_cyc.size(), 2);
    check("lock_next_time", (pulse_cyc.size() > 1) ? pulse_cyc[1] - p : -1, 7);
    check("lock_next_dir", (pulse_dir.size() > 1) ? pulse_dir[1] : -1, 0);

    // Reset during REPEAT, on the third pulse (p+7+28)
    p = cyc;
    btn_down = 1'b1;
    step(35);
    check("rep_pulse_before_rst", int'(en), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_enable", int'(en), 0);
    check("rst_mid_up_down", int'(ud), 1);
    step(2);
    clear_log();
    r = cyc;
    rst = 1'b1;
    step(12);
    check("rst_after_time", (pulse_cyc.size() > 0) ? pulse_cyc[0] - r : -1, 7);
    check("rst_after_dir", (pulse_dir.size() > 0) ? pulse_dir[0] : -1, 0);
    btn_down = 1'b0;
    step(15);

    // REPEAT_EN = 0 instance: one pulse for a long hold
    b_down = 1'b1;
    step(100);
    b_down = 1'b0;
    step(10);
    check("once_count", once_pulses, 1);

    check("no_back_to_back", back2back, 0);
    check("up_down_only_on_enable", ud_glitch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
